serial_frame_receiver: RTL and testbench
========================================

Name: serial_frame_receiver

Overview:
Parametrised successor to the team's single-lane bit-serial receiver. Assembles WIDTH-bit frames from LANES bits per clock, in LSB-first or MSB-first order. Buffers completed frames in a small FIFO with a valid/ready output handshake. Supports abort, back-to-back frames, overrun detection and a frame counter. Sits between the PUF response/ethernet serial path and word-wide consumers.

Parameters:
WIDTH, 32, frame width in bits; must be a multiple of LANES
LANES, 1, bits sampled per clock from RxD
MSB_FIRST, 0, 0 = first beat fills the low bits; 1 = first beat fills the high bits
FIFO_DEPTH, 2, completed-frame buffer entries; power of two, at least 2

Ports:
clk  in  1  system clock
reset  in  1  reset: one clock; reset is synchronous and active-low (0 = reset)
RxStart  in  1  frame start strobe
RxD  in  LANES  serial data lanes
RxAbort  in  1  discard the frame in progress
DataOut  out  WIDTH  head-of-FIFO frame
DataValid  out  1  DataOut holds a valid frame
DataReady  in  1  consumer accepts DataOut when DataValid && DataReady
RxBusy  out  1  high while in RECEIVE
RxDone  out  1  one-cycle pulse when a frame is completed (pushed or dropped)
Overrun  out  1  sticky: a completed frame was dropped because the FIFO was full
OverrunClr  in  1  clears Overrun
FrameCount  out  16  count of frames pushed into the FIFO; wraps at 0xFFFF -> 0

Behaviour:
- BEATS = WIDTH/LANES. Beat counter width is clog2(BEATS), minimum 1.
- Reset (reset==0 at a clk edge): state IDLE, beat counter 0, shift register 0, FIFO empty. Outputs: DataOut=0, DataValid=0, RxBusy=0, RxDone=0, Overrun=0, FrameCount=0. Reset mid-frame discards the partial frame. Reset overrides every other input.
- States: IDLE, RECEIVE.
  - IDLE: RxStart=1 -> RECEIVE, beat=0. RxD is not sampled in IDLE.
  - RECEIVE: RxD is sampled every cycle; beat increments.
    - LSB-first: beat k, lane i -> bit k*LANES+i.
    - MSB-first: beat k, lane i -> bit WIDTH-LANES-k*LANES+i.
- Timing: RxStart seen at cycle 0; beats are sampled at cycles 1..BEATS. On the last beat, the assembled word, including the last beat, is pushed. DataValid rises at cycle BEATS+1 if the FIFO was empty. The RxDone pulse is also at cycle BEATS+1.
- Back-to-back: RxStart=1 during the last beat -> stay in RECEIVE with beat=0; the next frame's beat 0 is sampled the following cycle. RxStart during any other RECEIVE beat is ignored.
- RxAbort=1 in RECEIVE -> IDLE next cycle. No push, no RxDone, FrameCount unchanged. Abort has priority over the last beat and over RxStart. RxAbort in IDLE has no effect, and RxStart is then honoured.
- FIFO: first-word fall-through. Pop on DataValid && DataReady.
  - Push and pop in the same cycle while full -> the push is accepted and occupancy is unchanged.
  - Push while full with no pop -> frame dropped, Overrun set, FrameCount unchanged.
  - Overrun set and OverrunClr in the same cycle -> set wins.
- DataOut is held stable while DataValid=1 && DataReady=0. Frames leave in arrival order.
- RxBusy = (state==RECEIVE), registered.

Decomposition:
- Package serial_rx_pkg: state enum (IDLE, RECEIVE), beats/counter-width constant functions, FrameCount width constant (16).
- Sub-module: rx_frame_fifo. Synchronous FWFT FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty, same clk/reset. Pointers carry one extra wrap bit.
- The top level keeps the FSM, the shift/assembly logic, and the Overrun/FrameCount logic.

Test Plan:
- WIDTH=8, LANES=1, LSB-first, DataReady=1. RxD 1,0,1,1,0,0,1,0 -> DataOut=0x4D; DataValid and RxDone high at cycle 9 only; FrameCount=1.
- Same RxD stream with MSB_FIRST=1 -> DataOut=0xB2.
- WIDTH=32, LANES=4. Nibbles 1,2,...,8 -> DataOut=0x87654321 at cycle 9. Then RxStart on beat 8 with nibbles 0xA..0x3 -> second frame valid at cycle 17 with no idle gap.
- FIFO_DEPTH=2, DataReady=0, three 8-bit frames 0x11, 0x22, 0x33 -> Overrun=1, FrameCount=2. Draining yields 0x11 then 0x22. OverrunClr -> Overrun=0.
- RxAbort at beat 3, then a new frame 0x5A -> only 0x5A is delivered; RxDone pulses once; RxBusy=0 the cycle after the abort.
- reset=0 for one cycle at beat 5 with the FIFO holding one frame -> all outputs 0 and FIFO empty. A following frame 0xC3 is received correctly.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// ---------------------------------------------------------------------------
// serial_rx_pkg
// Shared types and constants for the serial frame receiver slice.
//   rx_state_e   : receiver FSM states (IDLE, RECEIVE)
//   FRAME_CNT_W  : width of the pushed-frame counter
//   beats_of()   : number of clock beats per frame
//   cnt_width()  : counter width able to index n beats (minimum 1 bit)
// ---------------------------------------------------------------------------
package serial_rx_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RECEIVE = 1'b1
   } rx_state_e;

   localparam int FRAME_CNT_W = 16;

   function automatic int beats_of(input int width, input int lanes);
      return width / lanes;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// serial_frame_receiver_if
// Bundles the serial input side and the word-wide valid/ready output side of
// the receiver.
//   slave  : the receiver (samples RxStart/RxD/RxAbort/DataReady/OverrunClr,
//            drives DataOut/DataValid/RxBusy/RxDone/Overrun/FrameCount)
//   master : the environment around it (serial source plus word consumer)
// ---------------------------------------------------------------------------
interface serial_frame_receiver_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 1
);

   logic                                RxStart;
   logic [LANES-1:0]                    RxD;
   logic                                RxAbort;
   logic [WIDTH-1:0]                    DataOut;
   logic                                DataValid;
   logic                                DataReady;
   logic                                RxBusy;
   logic                                RxDone;
   logic                                Overrun;
   logic                                OverrunClr;
   logic [serial_rx_pkg::FRAME_CNT_W-1:0] FrameCount;

   modport slave (
      input  RxStart, RxD, RxAbort, DataReady, OverrunClr,
      output DataOut, DataValid, RxBusy, RxDone, Overrun, FrameCount
   );

   modport master (
      output RxStart, RxD, RxAbort, DataReady, OverrunClr,
      input  DataOut, DataValid, RxBusy, RxDone, Overrun, FrameCount
   );

endinterface

// File: rtl/rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// rx_frame_fifo
// Synchronous first-word fall-through FIFO for completed frames.
//   clk, reset  : clock, synchronous active-low reset
//   push        : write push_data (accepted when not full, or when full and
//                 popping in the same cycle)
//   push_data   : frame to store
//   pop         : consume the head entry (ignored when empty)
//   pop_data    : head entry, zero while empty
//   full, empty : occupancy flags
// Pointers carry one wrap bit beyond the address so full and empty are
// distinguishable when the addresses match.
// ---------------------------------------------------------------------------
module rx_frame_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers define
   // which entries are meaningful, and pop_data is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/serial_frame_receiver.sv
// ---------------------------------------------------------------------------
// serial_frame_receiver
// Assembles WIDTH-bit frames from LANES bits per clock and queues completed
// frames in an FWFT FIFO with a valid/ready output.
//   clk    : system clock
//   reset  : synchronous active-low reset
//   bus    : serial_frame_receiver_if.slave
//            RxStart/RxD/RxAbort in, DataOut/DataValid/DataReady handshake,
//            RxBusy, RxDone pulse, sticky Overrun with OverrunClr, FrameCount
// Beats are sampled on the cycles after RxStart; the frame is pushed on the
// edge that samples its last beat, so DataValid and RxDone appear one cycle
// later. RxStart on the last beat chains straight into the next frame.
// ---------------------------------------------------------------------------
module serial_frame_receiver
   import serial_rx_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int LANES      = 1,
   parameter int MSB_FIRST  = 0,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   serial_frame_receiver_if.slave  bus
);

   localparam int BEATS  = beats_of(WIDTH, LANES);
   localparam int BEAT_W = cnt_width(BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   rx_state_e                state_q;
   rx_state_e                state_next;
   logic [BEAT_W-1:0]        beat_q;
   logic [WIDTH-1:0]         sr_q;
   logic [WIDTH-1:0]         sr_next;
   logic                     sample;
   logic                     frame_end;
   logic                     done_q;
   logic                     overrun_q;
   logic [FRAME_CNT_W-1:0]   frame_cnt_q;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     fifo_pop;
   logic                     fifo_accept;
   logic                     drop;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_next;
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      state_next = state_q;
      sample     = 1'b0;
      frame_end  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.RxStart) state_next = RECEIVE;
         end
         RECEIVE: begin
            // Abort outranks both the last beat and a chained RxStart.
            if (bus.RxAbort) begin
               state_next = IDLE;
            end else begin
               sample = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  frame_end = 1'b1;
                  if (!bus.RxStart) state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.RxBusy = (state_q == RECEIVE);
   end

   // ---------------- assembly shift register ----------------
   // LSB-first shifts beats in from the top so beat 0 ends in the low lanes;
   // MSB-first shifts in from the bottom so beat 0 ends in the high lanes.
   generate
      if (BEATS == 1) begin : g_single
         assign sr_next = bus.RxD;
      end else if (MSB_FIRST != 0) begin : g_msb
         assign sr_next = {sr_q[WIDTH-LANES-1:0], bus.RxD};
      end else begin : g_lsb
         assign sr_next = {bus.RxD, sr_q[WIDTH-1:LANES]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         beat_q <= '0;
         sr_q   <= '0;
      end else begin
         // Beat restarts at 0 in IDLE, on abort and after the last beat.
         beat_q <= (sample && !frame_end) ? beat_q + 1'b1 : '0;
         if (sample) sr_q <= sr_next;
      end
   end

   // ---------------- frame buffer ----------------
   assign fifo_pop    = !fifo_empty && bus.DataReady;
   assign fifo_accept = frame_end && (!fifo_full || fifo_pop);
   assign drop        = frame_end && fifo_full && !fifo_pop;

   rx_frame_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (frame_end),
      .push_data (sr_next),
      .pop       (fifo_pop),
      .pop_data  (bus.DataOut),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.DataValid = !fifo_empty;

   // ---------------- status: RxDone, Overrun, FrameCount ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         done_q <= frame_end;
         // A drop in the same cycle as OverrunClr keeps Overrun set.
         if (drop)                 overrun_q <= 1'b1;
         else if (bus.OverrunClr)  overrun_q <= 1'b0;
         if (fifo_accept) frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   assign bus.RxDone     = done_q;
   assign bus.Overrun    = overrun_q;
   assign bus.FrameCount = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_receiver
// Directed bench for serial_frame_receiver. Three instances:
//   u8l : WIDTH=8,  LANES=1, LSB-first
//   u8m : WIDTH=8,  LANES=1, MSB-first (shares u8l's inputs)
//   u32 : WIDTH=32, LANES=4, LSB-first
// Inputs change 1 time unit after the rising edge and outputs are read there.
// ---------------------------------------------------------------------------
module tb_serial_frame_receiver;
   import serial_rx_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       rs8, rxd8, ab8, rdy8, clr8;
   logic       rs32, ab32, rdy32, clr32;
   logic [3:0] rxd32;

   int errors = 0;
   int checks = 0;

   serial_frame_receiver_if #(.WIDTH(8),  .LANES(1)) if8l ();
   serial_frame_receiver_if #(.WIDTH(8),  .LANES(1)) if8m ();
   serial_frame_receiver_if #(.WIDTH(32), .LANES(4)) if32 ();

   assign if8l.RxStart = rs8;   assign if8l.RxD = rxd8;   assign if8l.RxAbort = ab8;
   assign if8l.DataReady = rdy8; assign if8l.OverrunClr = clr8;
   assign if8m.RxStart = rs8;   assign if8m.RxD = rxd8;   assign if8m.RxAbort = ab8;
   assign if8m.DataReady = rdy8; assign if8m.OverrunClr = clr8;
   assign if32.RxStart = rs32;  assign if32.RxD = rxd32;  assign if32.RxAbort = ab32;
   assign if32.DataReady = rdy32; assign if32.OverrunClr = clr32;

   serial_frame_receiver #(.WIDTH(8), .LANES(1), .MSB_FIRST(0), .FIFO_DEPTH(2))
      u8l (.clk(clk), .reset(reset), .bus(if8l));
   serial_frame_receiver #(.WIDTH(8), .LANES(1), .MSB_FIRST(1), .FIFO_DEPTH(2))
      u8m (.clk(clk), .reset(reset), .bus(if8m));
   serial_frame_receiver #(.WIDTH(32), .LANES(4), .MSB_FIRST(0), .FIFO_DEPTH(2))
      u32 (.clk(clk), .reset(reset), .bus(if32));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Start strobe at the current cycle, then 8 LSB-first bits of w; returns
   // at cycle 9 relative to the strobe.
   task automatic send8(input logic [7:0] w);
      rs8 = 1'b1;
      tick();
      rs8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rxd8 = w[i];
         tick();
      end
      rxd8 = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      logic [7:0] w;

      reset = 1'b0;
      rs8 = 0; rxd8 = 0; ab8 = 0; rdy8 = 1; clr8 = 0;
      rs32 = 0; rxd32 = 0; ab32 = 0; rdy32 = 1; clr32 = 0;
      tick();
      tick();

      // ---- reset state ----
      check("rst_dataout",  32'(if8l.DataOut),    32'h0);
      check("rst_valid",    32'(if8l.DataValid),  32'h0);
      check("rst_busy",     32'(if8l.RxBusy),     32'h0);
      check("rst_done",     32'(if8l.RxDone),     32'h0);
      check("rst_overrun",  32'(if8l.Overrun),    32'h0);
      check("rst_count",    32'(if8l.FrameCount), 32'h0);
      check("rst_valid32",  32'(if32.DataValid),  32'h0);
      reset = 1'b1;
      tick();

      // ---- 8-bit frame, LSB-first and MSB-first from the same stream ----
      w = 8'h4D;  // stream 1,0,1,1,0,0,1,0
      rs8 = 1'b1;
      tick();
      rs8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rxd8 = w[i];
         if (i == 7) begin
            check("t1_valid_c8", 32'(if8l.DataValid), 32'h0);
            check("t1_done_c8",  32'(if8l.RxDone),    32'h0);
            check("t1_busy_c8",  32'(if8l.RxBusy),    32'h1);
         end
         tick();
      end
      rxd8 = 1'b0;
      check("t1_lsb_data",  32'(if8l.DataOut),    32'h4D);
      check("t1_lsb_valid", 32'(if8l.DataValid),  32'h1);
      check("t1_lsb_done",  32'(if8l.RxDone),     32'h1);
      check("t1_lsb_count", 32'(if8l.FrameCount), 32'h1);
      check("t1_lsb_busy",  32'(if8l.RxBusy),     32'h0);
      check("t2_msb_data",  32'(if8m.DataOut),    32'hB2);
      check("t2_msb_valid", 32'(if8m.DataValid),  32'h1);
      tick();
      check("t1_valid_c10", 32'(if8l.DataValid),  32'h0);
      check("t1_done_c10",  32'(if8l.RxDone),     32'h0);

      // ---- 32-bit, 4 lanes, back-to-back frames ----
      rs32 = 1'b1;
      tick();
      rs32 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         rxd32 = 4'(k + 1);
         if (k == 7) rs32 = 1'b1;
         tick();
      end
      rs32 = 1'b0;
      check("t3_f1_data",  32'(if32.DataOut),   32'h87654321);
      check("t3_f1_valid", 32'(if32.DataValid), 32'h1);
      check("t3_f1_done",  32'(if32.RxDone),    32'h1);
      check("t3_no_gap",   32'(if32.RxBusy),    32'h1);
      for (int k = 0; k < 8; k++) begin
         rxd32 = 4'(10 - k);  // A,9,8,...,3
         tick();
      end
      rxd32 = 4'h0;
      check("t3_f2_data",  32'(if32.DataOut),    32'h3456789A);
      check("t3_f2_valid", 32'(if32.DataValid),  32'h1);
      check("t3_f2_done",  32'(if32.RxDone),     32'h1);
      check("t3_f2_count", 32'(if32.FrameCount), 32'h2);

      // ---- overrun with a 2-deep FIFO ----
      pulse_reset();
      rdy8 = 1'b0;
      send8(8'h11);
      send8(8'h22);
      check("t4_no_ovr_yet", 32'(if8l.Overrun), 32'h0);
      send8(8'h33);
      check("t4_overrun",  32'(if8l.Overrun),    32'h1);
      check("t4_done",     32'(if8l.RxDone),     32'h1);
      check("t4_count",    32'(if8l.FrameCount), 32'h2);
      check("t4_head",     32'(if8l.DataOut),    32'h11);
      tick();
      check("t4_head_hold", 32'(if8l.DataOut),   32'h11);
      rdy8 = 1'b1;
      tick();
      check("t4_second",   32'(if8l.DataOut),    32'h22);
      check("t4_sec_valid", 32'(if8l.DataValid), 32'h1);
      tick();
      check("t4_drained",  32'(if8l.DataValid),  32'h0);
      check("t4_ovr_sticky", 32'(if8l.Overrun),  32'h1);
      clr8 = 1'b1;
      tick();
      clr8 = 1'b0;
      check("t4_ovr_clr",  32'(if8l.Overrun),    32'h0);

      // ---- abort at beat 3, then frame 0x5A ----
      rs8 = 1'b1;
      tick();
      rs8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rxd8 = 1'b1;
         tick();
      end
      ab8 = 1'b1;
      check("t5_busy_abort", 32'(if8l.RxBusy), 32'h1);
      tick();
      ab8 = 1'b0;
      check("t5_busy_after", 32'(if8l.RxBusy), 32'h0);
      check("t5_no_done",    32'(if8l.RxDone), 32'h0);
      tick();
      check("t5_no_valid",   32'(if8l.DataValid), 32'h0);
      send8(8'h5A);
      check("t5_data",   32'(if8l.DataOut),    32'h5A);
      check("t5_valid",  32'(if8l.DataValid),  32'h1);
      check("t5_done",   32'(if8l.RxDone),     32'h1);
      check("t5_count",  32'(if8l.FrameCount), 32'h3);
      tick();
      check("t5_done_once", 32'(if8l.RxDone),  32'h0);

      // ---- reset mid-frame with one frame buffered ----
      rdy8 = 1'b0;
      send8(8'h77);
      check("t6_buffered", 32'(if8l.DataValid), 32'h1);
      rs8 = 1'b1;
      tick();
      rs8 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rxd8 = 1'b1;
         tick();
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("t6_data",    32'(if8l.DataOut),    32'h0);
      check("t6_valid",   32'(if8l.DataValid),  32'h0);
      check("t6_busy",    32'(if8l.RxBusy),     32'h0);
      check("t6_done",    32'(if8l.RxDone),     32'h0);
      check("t6_overrun", 32'(if8l.Overrun),    32'h0);
      check("t6_count",   32'(if8l.FrameCount), 32'h0);
      tick();
      tick();
      check("t6_idle",    32'(if8l.RxBusy),     32'h0);
      send8(8'hC3);
      check("t6_new_data",  32'(if8l.DataOut),    32'hC3);
      check("t6_new_valid", 32'(if8l.DataValid),  32'h1);
      check("t6_new_count", 32'(if8l.FrameCount), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
